// File: rtl/bin_to_bcd_seq_pkg.sv
// ============================================================================
// bin_to_bcd_seq_pkg : shared state encoding and BCD digit constants
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package bin_to_bcd_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// bin_to_bcd_seq_if : start/done request bus between controller and converter
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bin_to_bcd_seq_if #(
  parameter int W = 8,
  parameter int N = 3
);

  logic           start;
  logic [W-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*N-1:0] bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq_add3_cell.sv
// ============================================================================
// add3_cell : double-dabble digit correction (digit >= 5 gets +3)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module add3_cell
  import bin_to_bcd_seq_pkg::*;
(
  input  wire logic [DIGIT_W-1:0] digit_i,
  output logic      [DIGIT_W-1:0] digit_o
);

  // Input never exceeds 9, so the sum tops out at 12 and cannot wrap.
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// bin_to_bcd_seq : sequential binary-to-BCD converter, one bit per clock
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int BCD_W = DIGIT_W * N;
  localparam int SR_W  = BCD_W + W;
  localparam int CNT_W = $clog2(W + 1);

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic [BCD_W-1:0]   corr_bcd;
  logic [SR_W-1:0]    corr_sr;
  logic [SR_W-1:0]    shifted;

  for (genvar i = 0; i < N; i++) begin : g_digit
    add3_cell u_add3 (
      .digit_i (sr_q[W + DIGIT_W*i +: DIGIT_W]),
      .digit_o (corr_bcd[DIGIT_W*i +: DIGIT_W])
    );
  end

  assign corr_sr = {corr_bcd, sr_q[W-1:0]};
  assign shifted = corr_sr << 1;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sr_d    = {{BCD_W{1'b0}}, bus.bin_in};
          cnt_d   = CNT_W'(W);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - CNT_W'(1);
        // Last shift: publish the result in the same edge.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

`default_nettype wire

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Sits directly upstream of the BCD-to-Excess-3 code converter. Each 4-bit slice of bcd_out is one BCD digit (0–9) and drives one Excess-3 converter instance.
- Uses a start/done handshake, so a controller can request a conversion and latch the digits when done pulses.

Parameters:
- W, 8, width of the binary input in bits.
- N, 3, number of BCD output digits. Must satisfy 10^N > 2^W−1; the W=8, N=3 pair meets this.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  W  unsigned binary operand; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out holds the new result in this cycle.
- bcd_out  output  4*N  packed BCD result; digit i occupies bits [4i+3:4i], with digit 0 as the least significant.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state is IDLE.
  - busy = 0, done = 0, bcd_out = 0.
  - The internal shift register and bit counter are 0.
- Internal state:
  - Shift register of width 4*N+W, holding the BCD accumulator in the upper field and the binary remainder in the lower field.
  - Bit counter of width clog2(W+1).
- IDLE:
  - If start = 1 at a rising edge: load the binary field with bin_in, clear the BCD field, set the counter to W, go to SHIFT, set busy = 1.
  - If start = 0: hold state.
- SHIFT: on each edge, run these steps in order.
  - Correct every BCD digit ≥ 5 by adding 3. This is combinational and uses all N digits in parallel.
  - Shift the whole register left by 1.
  - Decrement the counter.
- End of conversion: the edge on which the counter goes 1→0 does the final shift and also:
  - writes bcd_out with the shifted BCD field;
  - sets done = 1 and busy = 0;
  - returns to IDLE.
- Latency: start is sampled at edge k. The shifts occur at edges k+1 … k+W. done is high in the single cycle after edge k+W, i.e. W cycles after acceptance.
- Throughput: start may be asserted during the done cycle, because the FSM is in IDLE. Back-to-back conversions therefore complete every W+1 cycles.
- Handshake rules:
  - done is a single-cycle pulse and is never high while busy = 1.
  - start while busy = 1 is ignored, not queued.
  - bin_in changes after acceptance have no effect.
- bcd_out stability: bcd_out changes only on the final SHIFT edge. It holds the previous result throughout a conversion and indefinitely afterwards.
- Output ranges:
  - Every digit of bcd_out is always in 0–9.
  - No invalid BCD codes reach the downstream Excess-3 stage. The downstream default (high-Z) branch is therefore never exercised in normal operation.
- Reset mid-conversion: aborts immediately. All outputs return to their reset values, and no done pulse is produced for the aborted operation.
- Edge operands:
  - bin_in = 0 gives bcd_out = 0 after the full W cycles. There is no early exit.
  - bin_in = 2^W−1 must convert exactly, with no truncation.
- Width rules: the add-3 correction is 4-bit and cannot overflow, because the input is ≤ 9 and its result is ≤ 12 before the shift.

Decomposition:
- Shared package or include holds:
  - the state encodings (IDLE = 1'b0, SHIFT = 1'b1);
  - a DIGIT_W = 4 constant;
  - a BCD_MAX = 9 constant.
- Sub-module add3_cell: 4-bit combinational correction (in ≥ 5 ? in+3 : in), instantiated N times with a generate loop.
- The top level holds the FSM, counter, shift register and output registers.

Test Plan:
- Reset: hold rst_n = 0, then release; start = 1 with bin_in = 8'd0 → done pulses exactly 8 cycles after acceptance; bcd_out = 12'h000; busy is high for 8 cycles.
- Maximum operand: bin_in = 8'd255 → bcd_out = 12'h255 (digits 2,5,5) at the done pulse.
- Typical operands: bin_in = 8'd99 → 12'h099, then bin_in = 8'd100 → 12'h100. Issue them back-to-back, with the second start asserted during the first done cycle. The second done occurs 9 cycles after the first.
- Start while busy: start = 1 on cycle 3 of a conversion of 8'd37, with bin_in = 8'd200 → the start is ignored; the result is 12'h037; only one done pulse occurs; bcd_out remains 12'h037 afterwards.
- Reset mid-conversion: assert rst_n = 0 asynchronously (between edges) at cycle 4 of converting 8'd128 → busy, done and bcd_out drop to 0 immediately. After release, no done pulse appears until a new start is issued.
- Exhaustive: all bin_in values 0–255 → bcd_out equals the decimal digits of bin_in, every digit ≤ 9, and latency is always 8 cycles. Feed bcd_out into three Excess-3 converters and check each output equals digit+3.
